// File: rtl/div_16x8_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per cycle.
// Optional build macro DIV_EARLY_EXIT_EN: a dividend smaller than the divisor completes without iterating.
module div_16x8_seq #(
  parameter int          ITER_W = 5,
  parameter logic [15:0] DBZ_Q  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        dbz,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       dvd_q;
  logic [15:0]       quo_q;
  logic [7:0]        dvs_q;
  logic [8:0]        rem_q;
  logic [ITER_W-1:0] cnt_q;
  logic              dbz_q;

  logic              accept;
  logic              early;
  logic              last_step;
  logic [8:0]        p;
  logic [8:0]        diff;
  logic              qbit;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its data until then, and the block holds Q/R/dbz until out_ready.
  assign accept = in_valid && (state_q == IDLE);

`ifdef DIV_EARLY_EXIT_EN
  assign early = ({8'b0, B} > A);
`else
  assign early = 1'b0;
`endif

  assign p         = {rem_q[7:0], dvd_q[15]};
  assign qbit      = (p >= {1'b0, dvs_q});
  assign diff      = p - {1'b0, dvs_q};
  assign last_step = (cnt_q == ITER_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((B == 8'd0) || early) state_d = DONE;
          else                      state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_q <= A;
            dvs_q <= B;
            rem_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
            cnt_q <= ITER_W'(16);
            if (B == 8'd0) begin
              quo_q <= DBZ_Q;
              rem_q <= {1'b0, A[7:0]};
              dbz_q <= 1'b1;
              cnt_q <= '0;
            end else if (early) begin
              // A < B implies A fits in 8 bits, so it is the whole remainder.
              rem_q <= {1'b0, A[7:0]};
              cnt_q <= '0;
            end
          end
        end
        BUSY: begin
          rem_q <= qbit ? diff : p;
          quo_q <= {quo_q[14:0], qbit};
          dvd_q <= {dvd_q[14:0], 1'b0};
          cnt_q <= cnt_q - ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = quo_q;
  assign R         = rem_q[7:0];
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Scoreboard bench for div_16x8_seq: directed corner cases plus random operands vs. plain arithmetic.
module tb_div_16x8_seq;

  localparam int W = 30;  // {latency[4:0], dbz, Q[15:0], R[7:0]}

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [7:0]  B;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        dbz;
  logic        out_valid;
  logic        out_ready;

  logic [W-1:0] exp_q[$];
  logic [23:0]  op_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int lat_meas = 0;
  bit valid_seen = 0;

  div_16x8_seq dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
    .Q(Q), .R(R), .dbz(dbz), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // reference model: plain division, latency in edges counted from the accepting edge
  function automatic logic [W-1:0] model(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    if (b == 0) begin
      q = 16'hFFFF; r = a[7:0]; z = 1'b1; lat = 1;
    end else begin
      q = a / b; r = 8'(a % b); z = 1'b0; lat = 17;
`ifdef DIV_EARLY_EXIT_EN
      if (a < b) lat = 1;
`endif
    end
    return {5'(lat), z, q, r};
  endfunction

  // monitor: timestamps accepts and first out_valid, checks results on output handshake
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [23:0]  op;
    cyc++;
    if (!rst_n) begin
      valid_seen = 0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !valid_seen) begin
        valid_seen = 1;
        lat_meas = cyc - acc_cyc;
      end
      if (out_valid && out_ready) begin
        valid_seen = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(Q), 32'hDEAD);
        end else begin
          e  = exp_q.pop_front();
          op = op_q.pop_front();
          chk("q",       32'(Q),        32'(e[23:8]));
          chk("r",       32'(R),        32'(e[7:0]));
          chk("dbz",     32'(dbz),      32'(e[24]));
          chk("latency", 32'(lat_meas), 32'(e[29:25]));
          if (op[7:0] != 0) begin
            chk("identity", 32'(Q) * 32'(op[7:0]) + 32'(R), 32'(op[23:8]));
            chk("r_lt_b",   32'(R < op[7:0]), 32'd1);
          end
        end
      end
    end
  end

  // driver: present operands, push expectation, return after the accepting edge
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int waited;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    exp_q.push_back(model(a, b));
    op_q.push_back({a, b});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 16'($urandom);
    B = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      op_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] a, input logic [7:0] b);
    issue(a, b);
    drain();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; A = '0; B = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q",         32'(Q),         32'd0);
    chk("rst_r",         32'(R),         32'd0);
    chk("rst_dbz",       32'(dbz),       32'd0);
    rst_n = 1'b1;

    run(16'd1000, 8'd7);
    run(16'hFFFF, 8'd1);
    run(16'hFFFF, 8'd255);
    run(16'd65534, 8'd255);
    run(16'd1234, 8'd0);
    run(16'd0, 8'd5);
    run(16'd5, 8'd9);

    // backpressure: result and in_ready must hold while out_ready is low
    out_ready = 1'b0;
    issue(16'd500, 8'd9);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_q",        32'(Q),         32'd55);
      chk("bp_r",        32'(R),         32'd5);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_in_ready",  32'(in_ready),  32'd1);
    chk("bp_after_out_valid", 32'(out_valid), 32'd0);
    chk("bp_drained",         32'(exp_q.size()), 32'd0);

    // reset mid-operation abandons the result
    issue(16'd300, 8'd3);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    op_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_q",         32'(Q),         32'd0);
    run(16'd300, 8'd3);

    // random operands
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = (i % 8 == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      rb = (i % 64 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_16x8_seq.md
Name: div_16x8_seq

Overview:
- Sequential restoring divider: 16-bit dividend over 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder.
- Inverse-direction companion to the 8x8 multiplier library. Benches use it to recover operands from multiplier products, so exact and approximate product error can be measured in hardware.
- Valid/ready on both input and output, one quotient bit per cycle.

Parameters:
- ITER_W, 5, width of the iteration counter (must hold 0..16).
- DBZ_Q, 16'hFFFF, quotient value returned on divide-by-zero.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- A  in  16  dividend, sampled on input handshake
- B  in  8  divisor, sampled on input handshake
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- Q  out  16  quotient
- R  out  8  remainder
- dbz  out  1  divide-by-zero flag, qualified by out_valid
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result

Behaviour:
- Clock and reset: one clock, clk; synchronous active-low reset rst_n, sampled on the rising edge of clk only.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Q=0, R=0, dbz=0, counter=0, internal shift/remainder registers=0.
- Reset while BUSY or DONE: the operation is abandoned and no result is emitted.
- States are IDLE, BUSY and DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Input handshake is in_valid&&in_ready at a rising edge. It latches A into the dividend shift register and B into the divisor register, and clears the 9-bit partial remainder and the quotient register.
  - If B==0, go IDLE->DONE with Q=DBZ_Q, R=A[7:0], dbz=1.
  - Otherwise go IDLE->BUSY with counter=16.
- BUSY step, once per cycle:
  - p = {rem[7:0], dividend[15]}, 9 bits.
  - If p >= {1'b0,B}: rem = p - B and quotient bit = 1.
  - Otherwise: rem = p and quotient bit = 0.
  - Shift the quotient bit into Q LSB-first, shift the dividend left by 1, and decrement the counter.
  - When the counter would reach 0, go to DONE.
- Invariant: rem < B after every step, so rem[8] is always 0 after the subtract. R = rem[7:0].
- Latency: out_valid is first high on the 17th rising edge after the accepting edge (16 BUSY cycles).
- DONE: Q, R and dbz are held stable while out_valid=1 and out_ready=0, with no limit on backpressure. On out_valid&&out_ready, go DONE->IDLE. in_ready rises on the following cycle; no same-cycle re-accept.
- in_valid is ignored outside IDLE. A and B may change freely while BUSY without affecting the result.
- Arithmetic: unsigned only. Results satisfy A == Q*B + R and R < B.
  - Boundary: A=16'hFFFF, B=1 gives Q=16'hFFFF, R=0.
  - Boundary: A=0 gives Q=0, R=0 after the full 16 cycles (with the feature disabled).

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: at the input handshake with B!=0 and A<{8'b0,B}, go directly IDLE->DONE with Q=0, R=A[7:0], dbz=0, so out_valid rises on the next edge. All other operands behave as above.
- Undefined: every non-zero divisor takes the full 16 BUSY cycles.

Test Plan:
- A=1000, B=7 -> Q=142, R=6, dbz=0; out_valid first high exactly 17 edges after accept.
- A=16'hFFFF, B=1 -> Q=65535, R=0. A=16'hFFFF, B=255 -> Q=257, R=0. A=65534, B=255 -> Q=256, R=254.
- A=1234, B=0 -> DONE one edge after accept; Q=16'hFFFF, R=8'hD2, dbz=1.
- Backpressure: A=500, B=9, out_ready held 0 for 10 cycles after out_valid -> Q=55 and R=5 stable throughout, in_ready=0 throughout, then a single handshake, then IDLE.
- rst_n=0 for one edge at the 8th BUSY cycle of A=300, B=3 -> next cycle in_ready=1, out_valid=0, Q=0. A new op A=300, B=3 then yields Q=100, R=0.
- A=5, B=9:
  - With DIV_EARLY_EXIT_EN -> Q=0, R=5, out_valid one edge after accept.
  - Without it -> the same values after 17 edges.
- Also: 2000 random A/B pairs checked against Q*B+R==A with R<B.
